// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read-capture path: calibration FSM states,
// latency bounds and the default calibration data patterns.
package ddr_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CHECK,
      RUN,
      FAIL
   } rd_state_t;

   localparam int MINLAT = 2;
   localparam int BEATS  = 2;

   localparam logic [31:0] PAT_RISE_DEF = 32'hFFFF0000;
   localparam logic [31:0] PAT_FALL_DEF = 32'h0000FFFF;

endpackage

// File: rtl/dqs_rd_capture_if.sv
// Read-capture bundle between the controller/IDDR side (master) and the capture block (slave).
// Carries read strobes, IDDR data, the DQS gate and the aligned read word with calibration status.
interface dqs_rd_capture_if
   import ddr_rd_pkg::*;
#(
   parameter int DW = 32,
   parameter int LW = 4
);
   logic              StartCal;
   logic              ReadIssued;
   logic              CalReadReq;
   logic [DW-1:0]     RiseData;
   logic [DW-1:0]     FallData;
   logic              DQSgateL;
   logic [2*DW-1:0]   RdData;
   logic              RdValid;
   logic              CalDone;
   logic              CalFail;
   logic [LW-1:0]     RdLatency;

   modport master (
      output StartCal, ReadIssued, RiseData, FallData,
      input  CalReadReq, DQSgateL, RdData, RdValid, CalDone, CalFail, RdLatency
   );

   modport slave (
      input  StartCal, ReadIssued, RiseData, FallData,
      output CalReadReq, DQSgateL, RdData, RdValid, CalDone, CalFail, RdLatency
   );
endinterface

// File: rtl/rd_delay_line.sv
// Read-command delay line: sr[k] is a read strobe delayed k+1 cycles; taps give the beat window and DQS gate.
// Latency: combinational taps off a 1-cycle-delayed shift register; no backpressure, clr flushes in-flight reads.
module rd_delay_line
   import ddr_rd_pkg::*;
#(
   parameter int MAXLAT = 16,
   parameter int LW     = $clog2(MAXLAT)
) (
   input  logic          core_clk,
   input  logic          arst_n,
   input  logic          clr,
   input  logic          rd_in,
   input  logic [LW-1:0] lat,
   output logic          win,
   output logic          first,
   output logic          gate
);
   localparam int SRLEN = MAXLAT + 2;
   localparam int IW    = $clog2(SRLEN);

   logic [SRLEN-1:0] sr;
   logic [IW-1:0]    tap;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         sr <= '0;
      end else if (clr) begin
         sr <= '0;
      end else begin
         sr <= {sr[SRLEN-2:0], rd_in};
      end
   end

   assign tap   = IW'(lat);
   assign first = sr[tap];
   assign win   = sr[tap] | sr[tap + IW'(1)];
   // one preamble tap ahead of the two data beats
   assign gate  = sr[tap - IW'(2)] | sr[tap - IW'(1)] | sr[tap];

endmodule

// File: rtl/dqs_rd_capture.sv
// DQS read gate, beat alignment and read-latency calibration; RdValid/RdData trail ReadIssued by lat+2 cycles.
// No backpressure: reads are accepted whenever issued in RUN, all other read strobes are dropped.
module dqs_rd_capture
   import ddr_rd_pkg::*;
#(
   parameter int              DW       = 32,
   parameter int              MAXLAT   = 16,
   parameter logic [DW-1:0]   PAT_RISE = PAT_RISE_DEF,
   parameter logic [DW-1:0]   PAT_FALL = PAT_FALL_DEF
) (
   input  logic             MCLK,
   input  logic             ResetL,
   dqs_rd_capture_if.slave  bus
);
   localparam int            LW     = $clog2(MAXLAT);
   localparam int            CW     = $clog2(MAXLAT + BEATS + 1);
   localparam logic [CW-1:0] WEND   = CW'(MAXLAT + BEATS);
   localparam logic [LW-1:0] LATMIN = LW'(MINLAT);
   localparam logic [LW-1:0] LATMAX = LW'(MAXLAT - 1);

   rd_state_t      state;
   logic [LW-1:0]  lat;
   logic [CW-1:0]  wcnt;
   logic           m0, m1;
   logic           win, first, gate;
   logic           start_ok, rd_in, pat_ok, run_ok, gate_en;

   assign start_ok = bus.StartCal && (state == IDLE || state == RUN || state == FAIL);
   assign run_ok   = (state == RUN) && !bus.StartCal;
   assign rd_in    = bus.ReadIssued && ((state == ISSUE) || run_ok);
   assign pat_ok   = (bus.RiseData == PAT_RISE) && (bus.FallData == PAT_FALL);
   assign gate_en  = !start_ok && (state == ISSUE || state == WAIT || state == CHECK || state == RUN);

   rd_delay_line #(.MAXLAT(MAXLAT), .LW(LW)) u_dly (
      .core_clk (MCLK),
      .arst_n   (ResetL),
      .clr      (start_ok),
      .rd_in    (rd_in),
      .lat      (lat),
      .win      (win),
      .first    (first),
      .gate     (gate)
   );

   assign bus.RdLatency = lat;

   always_ff @(posedge MCLK or negedge ResetL) begin
      if (!ResetL) begin
         state          <= IDLE;
         lat            <= LATMIN;
         wcnt           <= '0;
         m0             <= 1'b0;
         m1             <= 1'b0;
         bus.CalReadReq <= 1'b0;
         bus.CalDone    <= 1'b0;
         bus.CalFail    <= 1'b0;
         bus.DQSgateL   <= 1'b1;
         bus.RdValid    <= 1'b0;
         bus.RdData     <= '0;
      end else begin
         bus.DQSgateL <= !(gate && gate_en);
         bus.RdValid  <= run_ok && win;
         if (run_ok && win) begin
            bus.RdData <= {bus.RiseData, bus.FallData};
         end

         case (state)
            IDLE, RUN, FAIL: begin
               if (bus.StartCal) begin
                  state          <= ISSUE;
                  lat            <= LATMIN;
                  bus.CalDone    <= 1'b0;
                  bus.CalFail    <= 1'b0;
                  bus.CalReadReq <= 1'b1;
               end
            end
            ISSUE: begin
               m0   <= 1'b0;
               m1   <= 1'b0;
               wcnt <= '0;
               if (bus.ReadIssued) begin
                  bus.CalReadReq <= 1'b0;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               // only the calibration read is in the delay line, so first picks the beat
               if (win && pat_ok) begin
                  if (first) m0 <= 1'b1;
                  else       m1 <= 1'b1;
               end
               if (wcnt == WEND) state <= CHECK;
               else              wcnt  <= wcnt + CW'(1);
            end
            CHECK: begin
               if (m0 && m1) begin
                  bus.CalDone <= 1'b1;
                  state       <= RUN;
               end else if (lat == LATMAX) begin
                  bus.CalFail <= 1'b1;
                  state       <= FAIL;
               end else begin
                  lat            <= lat + LW'(1);
                  bus.CalReadReq <= 1'b1;
                  state          <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
